// File: rtl/game_timer.sv
// Seconds timer for the Saper game: divides clk into a 1 s tick and counts
// elapsed time up to MAX_SEC, or counts down from a preset with a sticky timeout.
module game_timer #(
   parameter int unsigned TICK_DIV = 65_000_000,
   parameter int unsigned MAX_SEC  = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       halt,
   input  logic       clear,
   input  logic       down,
   input  logic [7:0] preset,
   output logic [7:0] seconds,
   output logic       running,
   output logic       sec_tick,
   output logic       timeout
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
   localparam logic [7:0] MAX8 = 8'(MAX_SEC);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic          mode, mode_n;
   logic [7:0]    sec_n, loaded, sec_step;
   logic          tick_n, timeout_n, running_n;
   logic          presc_wrap, terminal;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         presc    <= '0;
         mode     <= 1'b0;
         seconds  <= 8'd0;
         running  <= 1'b0;
         sec_tick <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         presc    <= presc_n;
         mode     <= mode_n;
         seconds  <= sec_n;
         running  <= running_n;
         sec_tick <= tick_n;
         timeout  <= timeout_n;
      end
   end

   // Next state; a tick on the halt cycle still counts, and a terminal tick beats the pause
   always_comb begin
      state_n    = state;
      presc_n    = presc;
      mode_n     = mode;
      sec_n      = seconds;
      tick_n     = 1'b0;
      timeout_n  = timeout;
      loaded     = (preset > MAX8) ? MAX8 : preset;
      presc_wrap = (presc == PLAST);
      sec_step   = mode ? (seconds - 8'd1) : (seconds + 8'd1);
      terminal   = mode ? (sec_step == 8'd0) : (sec_step >= MAX8);

      if (clear) begin
         state_n   = IDLE;
         presc_n   = '0;
         sec_n     = 8'd0;
         timeout_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  presc_n = '0;
                  mode_n  = down;
                  if (!down) begin
                     sec_n   = 8'd0;
                     state_n = RUN;
                  end else begin
                     sec_n = loaded;
                     if (loaded == 8'd0) begin
                        state_n   = DONE;
                        timeout_n = 1'b1;
                     end else begin
                        state_n = RUN;
                     end
                  end
               end
            end
            RUN: begin
               if (presc_wrap) begin
                  presc_n = '0;
                  tick_n  = 1'b1;
                  sec_n   = sec_step;
                  if (terminal) begin
                     state_n   = DONE;
                     timeout_n = 1'b1;
                  end else if (halt) begin
                     state_n = PAUSED;
                  end
               end else if (halt) begin
                  state_n = PAUSED;
               end else begin
                  presc_n = presc + PW'(1);
               end
            end
            PAUSED: begin
               if (start) state_n = RUN;
            end
            DONE: begin
               state_n = DONE;
            end
            default: state_n = IDLE;
         endcase
      end

      running_n = (state_n == RUN);
   end

endmodule

// File: tb/tb_game_timer.sv
// Scoreboarded bench for game_timer: two instances (MAX_SEC 99 and 3) share
// stimulus; a behavioural model predicts each cycle and a monitor compares.
module tb_game_timer;

   localparam int TD = 4;

   logic       clk;
   logic       rst_n, start, halt, clear, down;
   logic [7:0] preset;
   logic [7:0] sec_a, sec_b;
   logic       run_a, run_b, tick_a, tick_b, to_a, to_b;

   game_timer #(.TICK_DIV(TD), .MAX_SEC(99)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
      .down(down), .preset(preset), .seconds(sec_a), .running(run_a),
      .sec_tick(tick_a), .timeout(to_a));

   game_timer #(.TICK_DIV(TD), .MAX_SEC(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
      .down(down), .preset(preset), .seconds(sec_b), .running(run_b),
      .sec_tick(tick_b), .timeout(to_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] sec;
      logic       run;
      logic       tick;
      logic       to;
   } obs_t;

   typedef struct {
      bit run, paused, done, dn, tick, to;
      int secs, frac;
   } mdl_t;

   mdl_t m_a, m_b;
   obs_t q_a[$], q_b[$];
   int   nvec = 0;
   int   nerr = 0;

   function automatic mdl_t mreset();
      mdl_t r;
      r = '{default: 0};
      return r;
   endfunction

   // Behavioural reference: one clock of the timer rules
   function automatic mdl_t mstep(input mdl_t a, input int mx, input bit s, input bit h,
                                  input bit c, input bit d, input int pre);
      mdl_t r;
      r = a;
      r.tick = 0;
      if (c) begin
         r = mreset();
         r.dn = a.dn;
      end else if (a.run) begin
         if (a.frac == TD - 1) begin
            r.frac = 0;
            r.tick = 1;
            r.secs = a.dn ? a.secs - 1 : a.secs + 1;
            if (r.secs == (a.dn ? 0 : mx)) begin
               r.run = 0; r.done = 1; r.to = 1;
            end else if (h) begin
               r.run = 0; r.paused = 1;
            end
         end else if (h) begin
            r.run = 0; r.paused = 1;
         end else begin
            r.frac = a.frac + 1;
         end
      end else if (a.paused) begin
         if (s) begin r.run = 1; r.paused = 0; end
      end else if (!a.done && s) begin
         r.frac = 0;
         r.dn   = d;
         r.secs = d ? ((pre > mx) ? mx : pre) : 0;
         if (d && r.secs == 0) begin r.done = 1; r.to = 1; end
         else r.run = 1;
      end
      return r;
   endfunction

   function automatic obs_t mobs(input mdl_t a);
      obs_t o;
      o.sec  = 8'(a.secs);
      o.run  = a.run;
      o.tick = a.tick;
      o.to   = a.to;
      return o;
   endfunction

   // One clock of stimulus; the model's prediction goes to the scoreboard queues
   task automatic cyc(input bit s, input bit h, input bit c);
      start = s; halt = h; clear = c;
      @(posedge clk);
      if (!rst_n) begin
         m_a = mreset();
         m_b = mreset();
      end else begin
         m_a = mstep(m_a, 99, s, h, c, down, int'(preset));
         m_b = mstep(m_b, 3, s, h, c, down, int'(preset));
      end
      q_a.push_back(mobs(m_a));
      q_b.push_back(mobs(m_b));
      #1;
      start = 1'b0; halt = 1'b0; clear = 1'b0;
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Monitor: compares both instances against the queued predictions
   always @(negedge clk) begin
      obs_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         nvec++;
         if ({sec_a, run_a, tick_a, to_a} !== e) begin
            nerr++;
            $display("FAIL dut_a t=%0t: got sec=%0d run=%0b tick=%0b to=%0b, expected sec=%0d run=%0b tick=%0b to=%0b",
                     $time, sec_a, run_a, tick_a, to_a, e.sec, e.run, e.tick, e.to);
         end
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         nvec++;
         if ({sec_b, run_b, tick_b, to_b} !== e) begin
            nerr++;
            $display("FAIL dut_b t=%0t: got sec=%0d run=%0b tick=%0b to=%0b, expected sec=%0d run=%0b tick=%0b to=%0b",
                     $time, sec_b, run_b, tick_b, to_b, e.sec, e.run, e.tick, e.to);
         end
      end
   end

   initial begin
      int r;
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; clear = 1'b0; down = 1'b0; preset = 8'd0;
      m_a = mreset();
      m_b = mreset();
      repeat (3) cyc(0, 0, 0);
      rst_n = 1'b1;
      chk("reset_seconds", sec_a, 0);
      chk("reset_running", run_a, 0);
      chk("reset_timeout", to_a, 0);
      repeat (2) cyc(0, 0, 0);

      // count-up and saturation of the MAX_SEC=3 instance
      down = 1'b0;
      cyc(1, 0, 0);
      chk("up_running_next_cycle", run_a, 1);
      repeat (12) cyc(0, 0, 0);
      chk("sat_seconds", sec_b, 3);
      chk("sat_timeout", to_b, 1);
      chk("sat_running", run_b, 0);
      chk("up_seconds_after_12", sec_a, 3);
      cyc(1, 0, 0);
      repeat (20) cyc(0, 0, 0);
      chk("sat_hold_after_start", sec_b, 3);

      // count-down cases
      cyc(0, 0, 1);
      down = 1'b1; preset = 8'd2;
      cyc(1, 0, 0);
      chk("down_load_2", sec_a, 2);
      repeat (8) cyc(0, 0, 0);
      chk("down_reach_0", sec_a, 0);
      chk("down_timeout", to_a, 1);
      cyc(0, 0, 1);
      preset = 8'd200;
      cyc(1, 0, 0);
      chk("down_clamp_99", sec_a, 99);
      chk("down_clamp_max3", sec_b, 3);
      cyc(0, 0, 1);
      preset = 8'd0;
      cyc(1, 0, 0);
      chk("preset0_timeout", to_a, 1);
      chk("preset0_no_tick", tick_a, 0);
      repeat (4) cyc(0, 0, 0);

      // pause two cycles into a second, resume, tick lands two cycles later
      cyc(0, 0, 1);
      down = 1'b0;
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("paused_not_running", run_a, 0);
      down = 1'b1; preset = 8'd7;
      repeat (10) cyc(0, 0, 0);
      chk("paused_seconds_frozen", sec_a, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("resume_plus1_no_tick", tick_a, 0);
      cyc(0, 0, 0);
      chk("resume_plus2_tick", tick_a, 1);
      chk("resume_seconds", sec_a, 1);

      // halt on a tick edge
      repeat (3) cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("halt_tick_counted", tick_a, 1);
      chk("halt_tick_seconds", sec_a, 2);
      chk("halt_tick_paused", run_a, 0);
      cyc(0, 0, 0);

      // clear+start together, then clear on a tick edge
      cyc(1, 0, 1);
      chk("clear_start_seconds", sec_a, 0);
      chk("clear_start_idle", run_a, 0);
      down = 1'b0;
      cyc(1, 0, 0);
      repeat (3) cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("clear_on_tick_no_tick", tick_a, 0);
      chk("clear_on_tick_seconds", sec_a, 0);

      // asynchronous reset mid-second at seconds=5
      cyc(1, 0, 0);
      repeat (21) cyc(0, 0, 0);
      chk("pre_reset_seconds", sec_a, 5);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_seconds", sec_a, 0);
      chk("async_rst_running", run_a, 0);
      chk("async_rst_tick", tick_a, 0);
      chk("async_rst_timeout_b", to_b, 0);
      repeat (2) cyc(0, 0, 0);
      rst_n = 1'b1;
      repeat (5) cyc(0, 0, 0);
      chk("idle_after_reset", run_a, 0);

      // randomized traffic
      repeat (800) begin
         down   = 1'($urandom_range(0, 1));
         preset = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                              : 8'($urandom_range(0, 255));
         r = int'($urandom_range(0, 99));
         cyc(r < 15, (r >= 15) && (r < 25), r >= 97);
      end

      repeat (3) @(negedge clk);
      #1;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
